// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  // Width of one ALU slice, in bits.
  localparam int NIB_W = 4;

  // States of the sequencer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Named select codes for the functions used most often.
  localparam logic [3:0] S_ADD   = 4'b1001;
  localparam logic       M_ADD   = 1'b0;
  localparam logic [3:0] S_SUB   = 4'b0110;
  localparam logic       M_SUB   = 1'b0;
  localparam logic [3:0] S_NOT_A = 4'b0000;
  localparam logic       M_NOT_A = 1'b1;

endpackage

// File: rtl/alu_serial_seq_alu.sv
// 4-bit ALU slice, 181-style function set with active-high data.
// Cn / Cn4 are active-low carries; G / P are active-low lookahead terms.
module ALU (
  output logic [3:0] F,
  output logic       AeB,
  output logic       G,
  output logic       Cn4,
  output logic       P,
  input  logic [3:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  input  logic       Cn
);

  logic [3:0] w_t1;
  logic [3:0] w_t2;
  logic [4:0] w_sum;
  logic [4:0] w_gen;

  // Arithmetic result is t1 + t2 + carry; logic mode forces every internal
  // carry high, which yields the inverted xor of the two terms.  The carry
  // chain is evaluated regardless of mode so Cn4 is always reported.
  always_comb begin
    w_t1  = A | (B & {4{S[0]}}) | (~B & {4{S[1]}});
    w_t2  = (A & ~B & {4{S[2]}}) | (A & B & {4{S[3]}});
    w_sum = {1'b0, w_t1} + {1'b0, w_t2} + {4'b0000, ~Cn};
    w_gen = {1'b0, w_t1} + {1'b0, w_t2};
    F     = M ? ~(w_t1 ^ w_t2) : w_sum[3:0];
    AeB   = &F;
    Cn4   = ~w_sum[4];
    G     = ~w_gen[4];
    P     = ~(&w_t1);
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Nibble-serial ALU: operands are registered on start, then one 4-bit slice
// processes one nibble per cycle with a registered ripple carry.
module alu_serial_seq
  import alu_seq_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 start_ready,
  input  logic [3:0]           op_s,
  input  logic                 op_m,
  input  logic                 op_cn,
  input  logic [NIB_W*NIB-1:0] op_a,
  input  logic [NIB_W*NIB-1:0] op_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NIB_W*NIB-1:0] res_f,
  output logic                 res_cn4,
  output logic                 res_aeb,
  output logic                 busy
);

  localparam int W  = NIB_W * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_e        r_state;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_s;
  logic          r_m;
  logic          r_cn;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_f;
  logic          r_cn4;
  logic          r_aeb;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic          w_cin;
  logic [3:0]    w_f;
  logic          w_aeb;
  logic          w_cn4;
  logic          w_g;
  logic          w_p;
  logic          w_accept;
  logic          w_unused_gp;

  // Current nibble of the held operands and the carry feeding the slice.
  always_comb begin
    w_a_nib = r_a[{r_idx, 2'b00} +: NIB_W];
    w_b_nib = r_b[{r_idx, 2'b00} +: NIB_W];
    w_cin   = (r_idx == '0) ? r_cn : r_cn4;
  end

  ALU u_alu (
    .F   (w_f),
    .AeB (w_aeb),
    .G   (w_g),
    .Cn4 (w_cn4),
    .P   (w_p),
    .S   (r_s),
    .A   (w_a_nib),
    .B   (w_b_nib),
    .M   (r_m),
    .Cn  (w_cin)
  );

  // Lookahead outputs are not needed for a ripple sequence.
  assign w_unused_gp = w_g ^ w_p;

  assign start_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && res_ready);
  assign w_accept    = start && start_ready;
  assign res_valid   = (r_state == ST_DONE);
  assign busy        = (r_state == ST_RUN);
  assign res_f       = r_f;
  assign res_cn4     = r_cn4;
  assign res_aeb     = r_aeb;

  // Sequencer: accept, step one nibble per cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_cn    <= 1'b1;
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_cn4   <= 1'b1;
      r_aeb   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_f[{r_idx, 2'b00} +: NIB_W] <= w_f;
          r_cn4 <= w_cn4;
          r_aeb <= r_aeb & w_aeb;
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready && !start) r_state <= ST_IDLE;
        end
        default: ;
      endcase
      // A new operation from IDLE or straight out of DONE (no bubble).
      if (w_accept) begin
        r_s     <= op_s;
        r_m     <= op_m;
        r_cn    <= op_cn;
        r_a     <= op_a;
        r_b     <= op_b;
        r_idx   <= '0;
        r_aeb   <= 1'b1;
        r_state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: stimulus pushes expected results,
// a monitor pops and compares on every result handshake.
module tb_alu_serial_seq;
  import alu_seq_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct {
    logic [W-1:0] f;
    logic         cn4;
    logic         aeb;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start_ready;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0;
  logic         op_cn = 1'b1;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_f;
  logic         res_cn4;
  logic         res_aeb;
  logic         busy;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  alu_serial_seq #(.NIB(NIB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .op_s        (op_s),
    .op_m        (op_m),
    .op_cn       (op_cn),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_f       (res_f),
    .res_cn4     (res_cn4),
    .res_aeb     (res_aeb),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got f=%0h with empty scoreboard", res_f);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_f",   32'(res_f),   32'(e.f));
        chk("res_cn4", 32'(res_cn4), 32'(e.cn4));
        chk("res_aeb", 32'(res_aeb), 32'(e.aeb));
      end
    end
  end

  // Present an operation and hold start until the handshake edge.
  task automatic do_op(input logic [3:0] s, input logic m, input logic cn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ef, input logic ecn4, input logic eaeb,
                       input bit push);
    bit ok;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op_s = s; op_m = m; op_cn = cn; op_a = a; op_b = b;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start_ready) begin ok = 1; break; end
    end
    if (!ok) chk("start_ready_timeout", 32'd0, 32'd1);
    if (push) begin
      e.f = ef; e.cn4 = ecn4; e.aeb = eaeb;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called right after the accepting edge; counts edges until res_valid.
  // With poke set, a conflicting start is driven during the first RUN cycles.
  task automatic wait_valid_lat(input bit poke);
    int  lat;
    bit  got;
    lat = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_accept", 32'(busy), 32'd1);
      if (res_valid) begin got = 1; break; end
      @(posedge clk); #1;
      lat++;
      if (poke && lat <= 3) begin
        start = 1'b1; op_s = S_ADD; op_m = M_ADD; op_cn = 1'b0;
        op_a = 16'hFFFF; op_b = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
    end
    if (!got) chk("res_valid_timeout", 32'd0, 32'd1);
    else      chk("latency", 32'(lat), 32'd5);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_res_valid",   32'(res_valid),   32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_res_f",       32'(res_f),       32'd0);
    chk("rst_res_cn4",     32'(res_cn4),     32'd1);
    chk("rst_res_aeb",     32'(res_aeb),     32'd0);

    do_op(S_ADD, M_ADD, 1'b1, 16'h1234, 16'h0FFF, 16'h2233, 1'b1, 1'b0, 1); wait_valid_lat(0);
    do_op(S_ADD, M_ADD, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1); wait_valid_lat(0);
    do_op(S_SUB, M_SUB, 1'b1, 16'h5A5A, 16'h5A5A, 16'hFFFF, 1'b1, 1'b1, 1); wait_valid_lat(0);
    do_op(S_SUB, M_SUB, 1'b0, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1); wait_valid_lat(0);
    // Logic mode still reports the ripple carry of the top nibble.
    do_op(S_NOT_A, M_NOT_A, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1); wait_valid_lat(0);

    // Stall the result, ignore start while stalled, then chain with no bubble.
    @(posedge clk); #1 res_ready = 1'b0;
    do_op(S_NOT_A, M_NOT_A, 1'b1, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b1, 1); wait_valid_lat(0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1'b1; op_s = S_ADD; op_m = M_ADD; op_cn = 1'b1; op_a = 16'h00FF; op_b = 16'h0F01;
      @(negedge clk);
      chk("stall_valid",       32'(res_valid),   32'd1);
      chk("stall_f",           32'(res_f),       32'hFFFF);
      chk("stall_aeb",         32'(res_aeb),     32'd1);
      chk("stall_cn4",         32'(res_cn4),     32'd1);
      chk("stall_start_ready", 32'(start_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    begin
      exp_t e;
      e.f = 16'h1000; e.cn4 = 1'b1; e.aeb = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
    chk("chain_start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1 start = 1'b0;
    wait_valid_lat(0);

    // Reset in the second RUN cycle abandons the operation.
    do_op(S_ADD, M_ADD, 1'b1, 16'h1111, 16'h1111, 16'h0, 1'b0, 1'b0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy",        32'(busy),        32'd0);
    chk("abort_res_valid",   32'(res_valid),   32'd0);
    chk("abort_res_f",       32'(res_f),       32'd0);
    chk("abort_start_ready", 32'(start_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("abort_no_result", 32'(res_valid), 32'd0);

    // start while busy must not disturb the registered operands.
    do_op(S_SUB, M_SUB, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1); wait_valid_lat(1);
    do_op(S_ADD, M_ADD, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1); wait_valid_lat(0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
